// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: instruction handshake, register-file read ports and the
// ALU issue bundle handshake.
// The "master" modport is the issue stage itself. The "slave" modport is the
// surrounding environment, which supplies instructions and register data and
// consumes the issue bundles.
interface alu_issue_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic              iss_valid;
  logic              iss_ready;
  logic [3:0]        alu_op;
  logic [XLEN-1:0]   src1;
  logic [XLEN-1:0]   src2;
  logic [REG_AW-1:0] rd_addr;
  logic              rd_we;
  logic              illegal;

  modport master (
    input  instr_valid, instr, rs1_data, rs2_data, iss_ready,
    output instr_ready, rs1_addr, rs2_addr, iss_valid, alu_op, src1, src2,
           rd_addr, rd_we, illegal
  );

  modport slave (
    output instr_valid, instr, rs1_data, rs2_data, iss_ready,
    input  instr_ready, rs1_addr, rs2_addr, iss_valid, alu_op, src1, src2,
           rd_addr, rd_we, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I (OP, OP-IMM, LUI) decode/issue stage.
// It contains the decoder and a two-entry skid buffer (output register plus
// skid register).
// Optional macro ALU_ISSUE_ILLEGAL_EN:
//   - Defined: illegal words are issued as bundles flagged with illegal = 1.
//   - Undefined: illegal words are consumed silently.
module alu_issue_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  alu_issue_if.master bus
);

  typedef struct packed {
    logic              illegal;
    logic              rd_we;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   src2;
    logic [XLEN-1:0]   src1;
    logic [3:0]        alu_op;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] F7_STD  = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Map funct3 to an ALU code; alt selects SUB/SRA over ADD/SRL.
  function automatic logic [3:0] base_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? 4'b0001 : 4'b0000;
      3'b001:  op = 4'b0010;
      3'b010:  op = 4'b0011;
      3'b011:  op = 4'b0100;
      3'b100:  op = 4'b0101;
      3'b101:  op = alt ? 4'b0111 : 4'b0110;
      3'b110:  op = 4'b1000;
      3'b111:  op = 4'b1001;
      default: op = 4'b0000;
    endcase
    return op;
  endfunction

  state_t  state_q, state_d;
  bundle_t out_q, out_d, skid_q, skid_d;
  logic    iss_valid_q, instr_ready_q;

  bundle_t         dec;
  logic            dec_legal;
  logic            keep;
  logic            load;
  logic            drain;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] rs1_val;

  assign opcode        = bus.instr[6:0];
  assign f3            = bus.instr[14:12];
  assign f7            = bus.instr[31:25];
  assign bus.rs1_addr  = bus.instr[19:15];
  assign bus.rs2_addr  = bus.instr[24:20];
  // x0 always reads as zero, whatever the register file returns.
  assign rs1_val       = (bus.rs1_addr == '0) ? '0 : bus.rs1_data;

  // Decode the offered instruction into an issue bundle and a legality flag.
  always_comb begin
    dec         = '0;
    dec_legal   = 1'b0;
    dec.rd_addr = bus.instr[11:7];
    case (opcode)
      OPC_OP: begin
        dec_legal  = (f7 == F7_STD) ||
                     ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
        dec.alu_op = base_op(f3, f7[5]);
        dec.src1   = rs1_val;
        dec.src2   = bus.rs2_data;
      end
      OPC_IMM: begin
        dec.src1 = rs1_val;
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
          dec_legal  = (f7 == F7_STD) || ((f7 == F7_ALT) && (f3 == 3'b101));
          dec.alu_op = base_op(f3, f7[5]);
          dec.src2   = {{(XLEN-5){1'b0}}, bus.instr[24:20]};
        end else begin
          // No SUB immediate form: funct3 000 is always ADDI.
          dec_legal  = 1'b1;
          dec.alu_op = base_op(f3, 1'b0);
          dec.src2   = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
        end
      end
      OPC_LUI: begin
        dec_legal  = 1'b1;
        dec.alu_op = 4'b0000;
        dec.src1   = '0;
        dec.src2   = {bus.instr[31:12], 12'b0};
      end
      default: dec_legal = 1'b0;
    endcase
    if (dec_legal) begin
      dec.rd_we = (dec.rd_addr != '0);
    end else begin
      dec.alu_op = 4'b0000;
      dec.src1   = '0;
      dec.src2   = '0;
      dec.rd_we  = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
      dec.illegal = 1'b1;
`else
      dec.illegal = 1'b0;
`endif
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_EN
  assign keep = 1'b1;
`else
  assign keep = dec_legal;
`endif

  // An accepted word creates an entry only if it produces a bundle.
  // Illegal words are still handshaken, so they never stall the front end.
  assign load  = bus.instr_valid && instr_ready_q && !flush && keep;
  assign drain = iss_valid_q && bus.iss_ready;

  // Skid-buffer control: next state and next output/skid contents.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (load) begin
            state_d = ONE;
            out_d   = dec;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (load && drain) begin
            out_d = dec;
          end else if (load) begin
            state_d = TWO;
            skid_d  = dec;
          end else if (drain) begin
            state_d = EMPTY;
          end else begin
            state_d = ONE;
          end
        end
        TWO: begin
          if (drain) begin
            state_d = ONE;
            out_d   = skid_q;
          end else begin
            state_d = TWO;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State, data and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= EMPTY;
      out_q         <= '0;
      skid_q        <= '0;
      iss_valid_q   <= 1'b0;
      instr_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      out_q         <= out_d;
      skid_q        <= skid_d;
      iss_valid_q   <= (state_d != EMPTY);
      instr_ready_q <= (state_d != TWO);
    end
  end

  assign bus.instr_ready = instr_ready_q;
  assign bus.iss_valid   = iss_valid_q;
  assign bus.alu_op      = out_q.alu_op;
  assign bus.src1        = out_q.src1;
  assign bus.src2        = out_q.src2;
  assign bus.rd_addr     = out_q.rd_addr;
  assign bus.rd_we       = out_q.rd_we;
  assign bus.illegal     = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage.
// It applies directed vectors, hand-written backpressure, flush and reset
// sequences, and then randomized traffic checked against a queue-based model.
module tb_alu_issue_stage;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  alu_issue_if bus ();

  alu_issue_stage dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));

  always #5 clk = ~clk;

`ifdef ALU_ISSUE_ILLEGAL_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  typedef struct {
    logic [3:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
    logic        legal;
  } bnd_t;

  typedef struct {
    logic [31:0] w;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [3:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  rd;
    logic        we;
  } vec_t;

  // ALU code for each funct3, in the non-alternate form.
  localparam logic [3:0] BASE [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

  int n_chk  = 0;
  int n_fail = 0;

  // Reference decoder built directly from the instruction-set rules.
  function automatic bnd_t ref_decode(input logic [31:0] w, input logic [31:0] r1,
                                      input logic [31:0] r2);
    bnd_t b;
    logic [6:0] f7;
    logic [2:0] f3;
    bit alt;
    b  = '{default: '0};
    f7 = w[31:25];
    f3 = w[14:12];
    alt = (f7 == 7'h20);
    b.rd = w[11:7];
    case (w[6:0])
      7'h33: begin
        b.legal = (f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5));
        b.op = BASE[f3] + {3'b000, alt};
        b.s1 = r1;
        b.s2 = r2;
      end
      7'h13: begin
        b.s1 = r1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          b.legal = (f7 == 7'h00) || (alt && f3 == 3'd5);
          b.op = BASE[f3] + {3'b000, alt};
          b.s2 = {27'd0, w[24:20]};
        end else begin
          b.legal = 1'b1;
          b.op = BASE[f3];
          b.s2 = {{20{w[31]}}, w[31:20]};
        end
      end
      7'h37: begin
        b.legal = 1'b1;
        b.op = 4'd0;
        b.s1 = 32'd0;
        b.s2 = {w[31:12], 12'h000};
      end
      default: b.legal = 1'b0;
    endcase
    if (w[19:15] == 5'd0) b.s1 = 32'd0;
    if (b.legal) begin
      b.we = (b.rd != 5'd0);
      b.ill = 1'b0;
    end else begin
      b.op = 4'd0; b.s1 = 32'd0; b.s2 = 32'd0; b.we = 1'b0; b.ill = 1'b1;
    end
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_b(input string nm, input bnd_t e);
    chk({nm, ".valid"}, {31'd0, bus.iss_valid}, 32'd1);
    chk({nm, ".op"}, {28'd0, bus.alu_op}, {28'd0, e.op});
    chk({nm, ".src1"}, bus.src1, e.s1);
    chk({nm, ".src2"}, bus.src2, e.s2);
    chk({nm, ".rd_we"}, {31'd0, bus.rd_we}, {31'd0, e.we});
    chk({nm, ".illegal"}, {31'd0, bus.illegal}, {31'd0, e.ill});
    if (!e.ill) chk({nm, ".rd"}, {27'd0, bus.rd_addr}, {27'd0, e.rd});
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] w, input logic [31:0] r1, input logic [31:0] r2);
    bus.instr_valid = 1'b1;
    bus.instr = w;
    bus.rs1_data = r1;
    bus.rs2_data = r2;
  endtask

  // Random instruction: mostly legal forms, plus some odd funct7 and raw words.
  function automatic logic [31:0] gen();
    logic [31:0] r, w;
    logic [6:0] f7;
    int k;
    r = $urandom();
    k = $urandom_range(0, 6);
    f7 = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
    if ($urandom_range(0, 9) == 0) f7 = r[6:0];
    w = r;
    if ($urandom_range(0, 3) == 0) w[19:15] = 5'd0;
    case (k)
      0, 1: w = {f7, w[24:7], 7'h33};
      2, 3: begin
        w[6:0] = 7'h13;
        if (w[14:12] == 3'd1 || w[14:12] == 3'd5) w[31:25] = f7;
      end
      4: w[6:0] = 7'h37;
      5: w = (r[0]) ? 32'h0000007F : r;
      default: w = {f7, w[24:7], 7'h33};
    endcase
    return w;
  endfunction

  vec_t vt[7];
  bnd_t ea, eb, ec;
  bnd_t q[$];
  bnd_t nb;

  initial begin
    vt[0] = '{32'h002081B3, 32'd5,        32'd7,    4'd0, 32'd5,        32'd7,        5'd3, 1'b1};
    vt[1] = '{32'h402081B3, 32'd9,        32'd4,    4'd1, 32'd9,        32'd4,        5'd3, 1'b1};
    vt[2] = '{32'hFFF00093, 32'hDEADBEEF, 32'd0,    4'd0, 32'd0,        32'hFFFFFFFF, 5'd1, 1'b1};
    vt[3] = '{32'h40435293, 32'h80000000, 32'h123,  4'd7, 32'h80000000, 32'd4,        5'd5, 1'b1};
    vt[4] = '{32'h123453B7, 32'h55,       32'h66,   4'd0, 32'd0,        32'h12345000, 5'd7, 1'b1};
    vt[5] = '{32'h0020F033, 32'hF0F0,     32'h0FF0, 4'd9, 32'hF0F0,     32'h0FF0,     5'd0, 1'b0};
    vt[6] = '{32'h00513213, 32'h11,       32'h22,   4'd4, 32'h11,       32'd5,        5'd4, 1'b1};

    bus.instr_valid = 1'b0;
    bus.instr = 32'd0;
    bus.rs1_data = 32'd0;
    bus.rs2_data = 32'd0;
    bus.iss_ready = 1'b0;

    // Check the reset state.
    repeat (2) @(negedge clk);
    chk("rst.valid", {31'd0, bus.iss_valid}, 32'd0);
    chk("rst.op", {28'd0, bus.alu_op}, 32'd0);
    chk("rst.src1", bus.src1, 32'd0);
    chk("rst.src2", bus.src2, 32'd0);
    chk("rst.rd", {27'd0, bus.rd_addr}, 32'd0);
    chk("rst.we", {31'd0, bus.rd_we}, 32'd0);
    chk("rst.ill", {31'd0, bus.illegal}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst.ready", {31'd0, bus.instr_ready}, 32'd1);

    // Apply the directed vectors with iss_ready held high.
    bus.iss_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      offer(vt[i].w, vt[i].r1, vt[i].r2);
      #1;
      chk("vec.rs1_addr", {27'd0, bus.rs1_addr}, {27'd0, vt[i].w[19:15]});
      chk("vec.rs2_addr", {27'd0, bus.rs2_addr}, {27'd0, vt[i].w[24:20]});
      step();
      bus.instr_valid = 1'b0;
      chk("vec.valid", {31'd0, bus.iss_valid}, 32'd1);
      chk("vec.op", {28'd0, bus.alu_op}, {28'd0, vt[i].op});
      chk("vec.src1", bus.src1, vt[i].s1);
      chk("vec.src2", bus.src2, vt[i].s2);
      chk("vec.rd", {27'd0, bus.rd_addr}, {27'd0, vt[i].rd});
      chk("vec.we", {31'd0, bus.rd_we}, {31'd0, vt[i].we});
    end
    step();
    chk("vec.drained", {31'd0, bus.iss_valid}, 32'd0);

    // Backpressure: A and B are buffered, C waits; the bundles drain in order.
    ea = ref_decode(vt[0].w, vt[0].r1, vt[0].r2);
    eb = ref_decode(vt[1].w, vt[1].r1, vt[1].r2);
    ec = ref_decode(vt[4].w, vt[4].r1, vt[4].r2);
    bus.iss_ready = 1'b0;
    offer(vt[0].w, vt[0].r1, vt[0].r2); step();
    offer(vt[1].w, vt[1].r1, vt[1].r2); step();
    chk("bp.ready_two", {31'd0, bus.instr_ready}, 32'd0);
    chk_b("bp.A_hold", ea);
    offer(vt[4].w, vt[4].r1, vt[4].r2); step();
    chk("bp.ready_still", {31'd0, bus.instr_ready}, 32'd0);
    chk_b("bp.A_stable", ea);
    bus.iss_ready = 1'b1;
    step();
    chk_b("bp.B", eb);
    chk("bp.ready_back", {31'd0, bus.instr_ready}, 32'd1);
    step();
    bus.instr_valid = 1'b0;
    chk_b("bp.C", ec);
    step();
    chk("bp.empty", {31'd0, bus.iss_valid}, 32'd0);

    // Streaming: one bundle per cycle with no bubbles.
    for (int i = 0; i < 7; i++) begin
      offer(vt[i].w, vt[i].r1, vt[i].r2);
      nb = ref_decode(vt[i].w, vt[i].r1, vt[i].r2);
      #1;
      chk("stream.ready", {31'd0, bus.instr_ready}, 32'd1);
      step();
      chk_b("stream", nb);
    end
    bus.instr_valid = 1'b0;
    step();
    chk("stream.end", {31'd0, bus.iss_valid}, 32'd0);

    // Flush while in TWO; an instruction offered with flush is discarded.
    bus.iss_ready = 1'b0;
    offer(vt[0].w, 32'd1, 32'd2); step();
    offer(vt[1].w, 32'd1, 32'd2); step();
    chk("fl.two", {31'd0, bus.instr_ready}, 32'd0);
    flush = 1'b1;
    offer(vt[2].w, 32'd1, 32'd2);
    step();
    flush = 1'b0;
    bus.instr_valid = 1'b0;
    chk("fl.valid", {31'd0, bus.iss_valid}, 32'd0);
    chk("fl.ready", {31'd0, bus.instr_ready}, 32'd1);
    bus.iss_ready = 1'b1;
    flush = 1'b1;
    offer(vt[3].w, 32'd1, 32'd2);
    step();
    flush = 1'b0;
    bus.instr_valid = 1'b0;
    chk("fl.same_cycle", {31'd0, bus.iss_valid}, 32'd0);

    // Illegal word 0x0000007F.
    offer(32'h0000007F, 32'd3, 32'd4);
    step();
    bus.instr_valid = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
    nb = ref_decode(32'h0000007F, 32'd3, 32'd4);
    chk_b("ill.bundle", nb);
`else
    chk("ill.nobundle", {31'd0, bus.iss_valid}, 32'd0);
    chk("ill.ready", {31'd0, bus.instr_ready}, 32'd1);
`endif
    step();

    // Asynchronous reset while in TWO clears iss_valid immediately.
    bus.iss_ready = 1'b0;
    offer(vt[0].w, 32'd1, 32'd2); step();
    offer(vt[1].w, 32'd1, 32'd2); step();
    bus.instr_valid = 1'b0;
    chk("ar.before", {31'd0, bus.iss_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.valid", {31'd0, bus.iss_valid}, 32'd0);
    chk("ar.src2", bus.src2, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar.ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("ar.empty", {31'd0, bus.iss_valid}, 32'd0);

    // Randomized traffic against the queue model (state is EMPTY here).
    q.delete();
    for (int c = 0; c < 800; c++) begin
      logic [31:0] w, r1, r2;
      bit rdy, vld;
      rdy = (q.size() < 2);
      vld = (q.size() > 0);
      chk("rnd.ready", {31'd0, bus.instr_ready}, {31'd0, rdy});
      chk("rnd.valid", {31'd0, bus.iss_valid}, {31'd0, vld});
      if (vld) chk_b("rnd", q[0]);
      w = gen();
      r1 = $urandom();
      r2 = $urandom();
      flush = ($urandom_range(0, 39) == 0);
      bus.iss_ready = ($urandom_range(0, 2) != 0);
      bus.instr_valid = ($urandom_range(0, 3) != 0);
      bus.instr = w;
      bus.rs1_data = r1;
      bus.rs2_data = r2;
      #1;
      chk("rnd.rs1_addr", {27'd0, bus.rs1_addr}, {27'd0, w[19:15]});
      if (flush) begin
        q.delete();
      end else begin
        if (vld && bus.iss_ready) void'(q.pop_front());
        if (bus.instr_valid && rdy) begin
          nb = ref_decode(w, r1, r2);
          if (nb.legal || FEAT) q.push_back(nb);
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Decode/issue stage that drives the ALU's operation and operand interface. It accepts RV32I integer instructions (OP, OP-IMM, LUI) over a valid/ready handshake and reads two register-file ports combinationally. It then presents a registered alu_op/src1/src2/rd bundle to the execute stage over a second valid/ready handshake. A 2-entry skid buffer gives full throughput under backpressure.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
REG_AW, 5, register address width.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous flush: discard all buffered entries
instr_valid  in  1  instruction offered
instr_ready  out  1  stage can accept an instruction
instr  in  32  RV32I instruction word
rs1_addr  out  REG_AW  register-file read address 1, combinational from instr[19:15]
rs2_addr  out  REG_AW  register-file read address 2, combinational from instr[24:20]
rs1_data  in  XLEN  register-file read data 1, valid in the same cycle
rs2_data  in  XLEN  register-file read data 2, valid in the same cycle
iss_valid  out  1  issue bundle valid
iss_ready  in  1  execute stage accepts the bundle
alu_op  out  4  ALU operation code
src1  out  XLEN  ALU operand 1
src2  out  XLEN  ALU operand 2
rd_addr  out  REG_AW  destination register
rd_we  out  1  destination write enable (0 when rd = x0)
illegal  out  1  bundle carries an illegal instruction (only with the optional feature)

Behaviour:
- alu_op encoding: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND. Codes 1010 to 1111 are never emitted.
- OP (opcode 0110011):
  - funct7 must be 0000000, except SUB and SRA, which use 0100000.
  - src1 = rs1_data, src2 = rs2_data.
- OP-IMM (opcode 0010011):
  - immediate = sign-extended instr[31:20].
  - SLLI/SRLI: funct7 = 0000000. SRAI: funct7 = 0100000. src2 = zero-extended shamt instr[24:20].
  - There is no SUB immediate form; funct3 000 decodes to ADD.
- LUI (opcode 0110111): alu_op ADD, src1 = 0, src2 = {instr[31:12], 12'b0}.
- Any other opcode, or a funct7 not listed above, is illegal.
- src1 is forced to 0 when rs1_addr = 0, regardless of rs1_data.
- rd_we = (rd_addr != 0).
- Handshake:
  - A transfer occurs when valid && ready.
  - Latency is 1 cycle: an instruction accepted in cycle N appears on the outputs in cycle N+1.
  - iss_valid, once asserted, holds and the bundle stays stable until accepted.
- State machine:
  - States: EMPTY (no entry), ONE (output register valid), TWO (output register and skid register valid).
  - instr_ready = (state != TWO). It is a registered signal and does not depend on iss_ready combinationally.
  - EMPTY: on accept, go to ONE.
  - ONE:
    - accept and drain together: stay in ONE; the new entry loads the output register.
    - accept only: go to TWO; the new entry goes to the skid register.
    - drain only: go to EMPTY.
  - TWO:
    - drain: skid register moves to the output register; go to ONE.
    - no input is accepted while in TWO.
- Ordering is strictly FIFO and no entry is ever lost or duplicated.
- flush: next state is EMPTY and iss_valid = 0 in the following cycle. An instruction offered in the same cycle as flush is discarded. flush has priority over all other events.
- Reset: iss_valid = 0, instr_ready = 1 after deassertion, state = EMPTY. alu_op, src1, src2, rd_addr, rd_we and illegal all reset to 0. Reset asserted mid-operation discards all entries immediately.

Optional Feature:
Macro ALU_ISSUE_ILLEGAL_EN.
- Defined: an illegal instruction is issued as a bundle with illegal = 1, alu_op = 0000, src1 = src2 = 0, rd_we = 0. It follows the normal handshake and ordering rules.
- Undefined: an illegal instruction is accepted (consumed) but produces no bundle, and illegal is tied to 0.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1_data=5, rs2_data=7 -> next cycle: iss_valid=1, alu_op=0000, src1=5, src2=7, rd_addr=3, rd_we=1.
- SUB x3,x1,x2 (0x402081B3) -> alu_op=0001. ADDI x1,x0,-1 (0xFFF00093) -> alu_op=0000, src1=0 even if rs1_data=0xDEADBEEF, src2=0xFFFFFFFF.
- SRAI x5,x6,4 (0x40435293) -> alu_op=0111, src2=4. LUI x7,0x12345 (0x123453B7) -> src1=0, src2=0x12345000, rd_addr=7.
- iss_ready=0 while three back-to-back instructions are offered -> two are accepted, then instr_ready=0. Release iss_ready -> the bundles drain in order A, B, and C is then accepted.
- Streaming with iss_ready=1 throughout -> one bundle per cycle with no bubbles. Assert flush while in state TWO -> iss_valid=0 and instr_ready=1 in the next cycle.
- Word 0x0000007F (illegal): with ALU_ISSUE_ILLEGAL_EN -> a bundle with illegal=1, rd_we=0. Without it -> the word is accepted and no bundle appears. Separately, pulse rst_n low while in state TWO -> iss_valid=0 immediately.
